// File: rtl/nap_countdown_ctrl.sv
// rtl/nap_countdown_ctrl.sv - nap timer countdown controller feeding the BCD decrement stage
// Holds HH:MM:SS as six BCD digits, divides the clock into ticks and sequences decrement requests.
module nap_countdown_ctrl #(
   parameter int TICK_DIV = 50000000,
   parameter int PRESC_W  = 26
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       load,
   input  logic       run,
   input  logic       alarm_ack,
   input  logic [3:0] set_hour10,
   input  logic [3:0] set_hour1,
   input  logic [3:0] set_minute10,
   input  logic [3:0] set_minute1,
   input  logic [3:0] set_second10,
   input  logic [3:0] set_second1,
   output logic       dec_start,
   output logic [3:0] dec_hour10,
   output logic [3:0] dec_hour1,
   output logic [3:0] dec_minute10,
   output logic [3:0] dec_minute1,
   output logic [3:0] dec_second10,
   output logic [3:0] dec_second1,
   input  logic [3:0] dec_get_hour10,
   input  logic [3:0] dec_get_hour1,
   input  logic [3:0] dec_get_minute10,
   input  logic [3:0] dec_get_minute1,
   input  logic [3:0] dec_get_second10,
   input  logic [3:0] dec_get_second1,
   input  logic       dec_complete,
   input  logic       dec_is_zero,
   output logic [3:0] time_hour10,
   output logic [3:0] time_hour1,
   output logic [3:0] time_minute10,
   output logic [3:0] time_minute1,
   output logic [3:0] time_second10,
   output logic [3:0] time_second1,
   output logic       running,
   output logic       alarm
);

   typedef enum logic [2:0] {IDLE, PAUSED, COUNT, REQ, ALARM} stateType;

   stateType           state, stateNext;
   logic [23:0]        timeDigits, timeNext, setDigits, getDigits;
   logic [PRESC_W-1:0] prescaler, prescNext, prescStep;
   logic               prescWrap;
   logic               tickPending, tickPendNext;
   logic               loadPending, loadPendNext;

   assign setDigits = {set_hour10, set_hour1, set_minute10, set_minute1, set_second10, set_second1};
   assign getDigits = {dec_get_hour10, dec_get_hour1, dec_get_minute10,
                       dec_get_minute1, dec_get_second10, dec_get_second1};

   assign prescWrap = (prescaler == PRESC_W'(TICK_DIV - 1));
   assign prescStep = prescWrap ? '0 : prescaler + 1'b1;

   always_comb begin
      stateNext    = state;
      timeNext     = timeDigits;
      prescNext    = prescaler;
      tickPendNext = tickPending;
      loadPendNext = loadPending;
      // While a decrement is in flight a load is deferred until its completion.
      if (load && state != REQ) begin
         stateNext    = PAUSED;
         timeNext     = setDigits;
         prescNext    = '0;
         tickPendNext = 1'b0;
      end else begin
         case (state)
            IDLE: ;
            PAUSED: begin
               if (run) stateNext = (timeDigits == '0) ? ALARM : COUNT;
            end
            COUNT: begin
               if (!run) begin
                  stateNext = PAUSED;
               end else begin
                  prescNext = prescStep;
                  if (prescWrap || tickPending) begin
                     tickPendNext = 1'b0;
                     stateNext    = REQ;
                  end
               end
            end
            REQ: begin
               prescNext = prescStep;
               if (prescWrap) tickPendNext = 1'b1;
               if (dec_complete) begin
                  loadPendNext = 1'b0;
                  if (dec_is_zero) begin
                     timeNext  = '0;
                     stateNext = ALARM;
                  end else if (loadPending || load) begin
                     timeNext     = setDigits;
                     prescNext    = '0;
                     tickPendNext = 1'b0;
                     stateNext    = PAUSED;
                  end else begin
                     timeNext = getDigits;
                     if (getDigits == '0) stateNext = ALARM;
                     else if (run)        stateNext = COUNT;
                     else                 stateNext = PAUSED;
                  end
               end else if (load) begin
                  loadPendNext = 1'b1;
               end
            end
            ALARM: begin
               prescNext    = '0;
               tickPendNext = 1'b0;
               if (alarm_ack) stateNext = IDLE;
            end
            default: stateNext = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         timeDigits  <= '0;
         prescaler   <= '0;
         tickPending <= 1'b0;
         loadPending <= 1'b0;
      end else begin
         state       <= stateNext;
         timeDigits  <= timeNext;
         prescaler   <= prescNext;
         tickPending <= tickPendNext;
         loadPending <= loadPendNext;
      end
   end

   assign dec_start = (state == REQ);
   assign running   = (state == COUNT) || (state == REQ);
   assign alarm     = (state == ALARM);

   assign {time_hour10, time_hour1, time_minute10, time_minute1, time_second10, time_second1} = timeDigits;
   assign {dec_hour10, dec_hour1, dec_minute10, dec_minute1, dec_second10, dec_second1}       = timeDigits;

endmodule

// File: tb/tb_nap_countdown_ctrl.sv
// tb/tb_nap_countdown_ctrl.sv - self-checking bench for nap_countdown_ctrl with a decrement-stage stub
module tb_nap_countdown_ctrl;

   localparam int TD = 10;
   localparam int M_IDLE = 0, M_PAUSED = 1, M_COUNT = 2, M_REQ = 3, M_ALARM = 4;

   logic        clock = 1'b0;
   logic        reset, load, run, alarm_ack;
   logic [23:0] setVal, getVal;
   logic        dec_complete, dec_is_zero;
   logic        dec_start, running, alarm;
   logic [3:0]  dec_hour10, dec_hour1, dec_minute10, dec_minute1, dec_second10, dec_second1;
   logic [3:0]  time_hour10, time_hour1, time_minute10, time_minute1, time_second10, time_second1;
   logic [23:0] timeAct, decAct;

   assign timeAct = {time_hour10, time_hour1, time_minute10, time_minute1, time_second10, time_second1};
   assign decAct  = {dec_hour10, dec_hour1, dec_minute10, dec_minute1, dec_second10, dec_second1};

   nap_countdown_ctrl #(.TICK_DIV(TD), .PRESC_W(4)) dut (
      .clock(clock), .reset(reset), .load(load), .run(run), .alarm_ack(alarm_ack),
      .set_hour10(setVal[23:20]), .set_hour1(setVal[19:16]), .set_minute10(setVal[15:12]),
      .set_minute1(setVal[11:8]), .set_second10(setVal[7:4]), .set_second1(setVal[3:0]),
      .dec_start(dec_start),
      .dec_hour10(dec_hour10), .dec_hour1(dec_hour1), .dec_minute10(dec_minute10),
      .dec_minute1(dec_minute1), .dec_second10(dec_second10), .dec_second1(dec_second1),
      .dec_get_hour10(getVal[23:20]), .dec_get_hour1(getVal[19:16]), .dec_get_minute10(getVal[15:12]),
      .dec_get_minute1(getVal[11:8]), .dec_get_second10(getVal[7:4]), .dec_get_second1(getVal[3:0]),
      .dec_complete(dec_complete), .dec_is_zero(dec_is_zero),
      .time_hour10(time_hour10), .time_hour1(time_hour1), .time_minute10(time_minute10),
      .time_minute1(time_minute1), .time_second10(time_second10), .time_second1(time_second1),
      .running(running), .alarm(alarm)
   );

   always #5 clock = ~clock;

   int          checks = 0, errors = 0, cyc = 0;
   bit          modelValid = 0, chaos = 0, forceComplete = 0;
   bit          stubBusy = 0;
   int          stubCnt = 0;
   int          mMode = M_IDLE, mPhase = 0;
   bit          mOwed = 0, mLoadLater = 0;
   logic [23:0] mTime = '0;

   task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [23:0] bcd_dec(input logic [23:0] t);
      int s, h, m, x;
      s = int'(t[23:20]) * 36000 + int'(t[19:16]) * 3600 + int'(t[15:12]) * 600
        + int'(t[11:8]) * 60 + int'(t[7:4]) * 10 + int'(t[3:0]);
      if (s > 0) s--;
      h = s / 3600;
      m = (s / 60) % 60;
      x = s % 60;
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
   endfunction

   // Decrement stage stand-in: answers each request after 3..6 cycles.
   task automatic stub_drive();
      dec_complete = 1'b0;
      dec_is_zero  = 1'b0;
      if (reset) begin
         stubBusy = 0;
      end else if (forceComplete) begin
         dec_complete  = 1'b1;
         getVal        = 24'($urandom);
         forceComplete = 0;
      end else if (stubBusy) begin
         stubCnt--;
         if (stubCnt == 0) begin
            stubBusy     = 0;
            dec_complete = 1'b1;
            if (chaos && $urandom_range(0, 9) == 0) begin
               dec_is_zero = 1'b1;
               getVal      = 24'($urandom);
            end else begin
               dec_is_zero = (decAct == 24'h0);
               getVal      = bcd_dec(decAct);
            end
         end
      end else if (dec_start) begin
         stubBusy = 1;
         stubCnt  = $urandom_range(2, 5);
      end else if (chaos && $urandom_range(0, 29) == 0) begin
         dec_complete = 1'b1;
         dec_is_zero  = 1'($urandom_range(0, 1));
         getVal       = 24'($urandom);
      end
   endtask

   task automatic apply_load();
      mTime  = setVal;
      mPhase = 0;
      mOwed  = 0;
      mMode  = M_PAUSED;
   endtask

   task automatic model_step();
      bit wrapped, takeLoad;
      if (reset) begin
         mMode = M_IDLE; mTime = '0; mPhase = 0; mOwed = 0; mLoadLater = 0;
         modelValid = 1;
         return;
      end
      wrapped = (mPhase == TD - 1);
      if (mMode == M_REQ) begin
         mPhase = wrapped ? 0 : mPhase + 1;
         if (wrapped) mOwed = 1;
         if (!dec_complete) begin
            if (load) mLoadLater = 1;
         end else begin
            takeLoad   = mLoadLater || load;
            mLoadLater = 0;
            if (dec_is_zero) begin
               mTime = '0;
               mMode = M_ALARM;
            end else if (takeLoad) begin
               apply_load();
            end else begin
               mTime = getVal;
               mMode = (getVal == 24'h0) ? M_ALARM : (run ? M_COUNT : M_PAUSED);
            end
         end
      end else if (load) begin
         apply_load();
      end else if (mMode == M_ALARM) begin
         mPhase = 0;
         mOwed  = 0;
         if (alarm_ack) mMode = M_IDLE;
      end else if (mMode == M_PAUSED) begin
         if (run) mMode = (mTime == 24'h0) ? M_ALARM : M_COUNT;
      end else if (mMode == M_COUNT) begin
         if (!run) begin
            mMode = M_PAUSED;
         end else begin
            mPhase = wrapped ? 0 : mPhase + 1;
            if (wrapped || mOwed) begin
               mOwed = 0;
               mMode = M_REQ;
            end
         end
      end
   endtask

   task automatic compare_model();
      logic [50:0] expVec, actVec;
      expVec = {mMode == M_REQ, mMode == M_COUNT || mMode == M_REQ, mMode == M_ALARM, mTime, mTime};
      actVec = {dec_start, running, alarm, timeAct, decAct};
      checks++;
      if (actVec !== expVec) begin
         errors++;
         $display("FAIL model cycle %0d: got start/run/alarm=%b%b%b time=%h dec=%h, expected %b%b%b time=%h",
                  cyc, dec_start, running, alarm, timeAct, decAct,
                  expVec[50], expVec[49], expVec[48], mTime);
      end
   endtask

   task automatic advance();
      model_step();
      @(posedge clock);
      @(negedge clock);
      cyc++;
      if (modelValid) compare_model();
   endtask

   task automatic cycle();
      stub_drive();
      advance();
   endtask

   logic [23:0] tq[$];
   logic [23:0] steps[3];
   logic [23:0] prevTime, got;
   logic        prevDs;
   int          rises, r0, r1;
   bit          done;

   initial begin
      reset = 1'b1; load = 1'b0; run = 1'b0; alarm_ack = 1'b0;
      setVal = '0; getVal = '0; dec_complete = 1'b0; dec_is_zero = 1'b0;
      @(negedge clock);
      cycle();
      cycle();
      reset = 1'b0;
      check_lit("reset_time", 32'(timeAct), 32'h0);
      check_lit("reset_flags", 32'({dec_start, running, alarm}), 32'h0);

      // 00:00:03 counts down to alarm, one request every TD cycles
      setVal = 24'h000003; load = 1'b1; cycle(); load = 1'b0;
      check_lit("t1_loaded", 32'(timeAct), 32'h000003);
      check_lit("t1_paused", 32'(running), 32'h0);
      run = 1'b1; rises = 0; r0 = 0; r1 = 0;
      prevDs = dec_start; prevTime = timeAct; tq.delete();
      for (int i = 0; i < 120 && !alarm; i++) begin
         cycle();
         if (dec_start && !prevDs) begin
            if (rises == 0) r0 = cyc;
            if (rises == 1) r1 = cyc;
            rises++;
         end
         if (timeAct !== prevTime) tq.push_back(timeAct);
         prevDs = dec_start; prevTime = timeAct;
      end
      steps[0] = 24'h000002; steps[1] = 24'h000001; steps[2] = 24'h000000;
      check_lit("t1_requests", 32'(rises), 32'd3);
      check_lit("t1_interval", 32'(r1 - r0), 32'd10);
      check_lit("t1_steps", 32'(tq.size()), 32'd3);
      for (int i = 0; i < 3; i++) begin
         got = (i < tq.size()) ? tq[i] : 24'heeeeee;
         check_lit("t1_step_value", 32'(got), 32'(steps[i]));
      end
      check_lit("t1_alarm", 32'(alarm), 32'h1);
      check_lit("t1_not_running", 32'(running), 32'h0);

      // dec_start held until the strobe, result latched on the strobe edge
      setVal = 24'h000100; load = 1'b1; cycle(); load = 1'b0;
      for (int i = 0; i < 40 && !dec_start; i++) cycle();
      check_lit("t2_start", 32'(dec_start), 32'h1);
      done = 0;
      for (int i = 0; i < 20 && !done; i++) begin
         stub_drive();
         if (dec_complete) begin
            check_lit("t2_start_held", 32'(dec_start), 32'h1);
            check_lit("t2_time_before", 32'(timeAct), 32'h000100);
            advance();
            check_lit("t2_start_dropped", 32'(dec_start), 32'h0);
            check_lit("t2_time_after", 32'(timeAct), 32'h000059);
            done = 1;
         end else begin
            advance();
         end
      end
      check_lit("t2_complete_seen", 32'(done), 32'h1);

      // pausing mid-prescale only delays the next tick by the paused cycles
      setVal = 24'h010000; load = 1'b1; cycle(); load = 1'b0;
      for (int i = 0; i < 40 && !dec_start; i++) cycle();
      r0 = cyc;
      for (int i = 0; i < 20 && timeAct !== 24'h005959; i++) cycle();
      check_lit("t3_first_tick", 32'(timeAct), 32'h005959);
      for (int i = 0; i < 3; i++) cycle();
      run = 1'b0;
      for (int i = 0; i < 7; i++) cycle();
      check_lit("t3_paused", 32'({running, timeAct}), 32'h0005959);
      run = 1'b1;
      for (int i = 0; i < 40 && !dec_start; i++) cycle();
      r1 = cyc;
      check_lit("t3_resume_interval", 32'(r1 - r0), 32'd18);
      for (int i = 0; i < 20 && dec_start; i++) cycle();
      check_lit("t3_second_tick", 32'(timeAct), 32'h005958);

      // load during a request discards the decrement result
      run = 1'b0;
      setVal = 24'h000009; load = 1'b1; cycle(); load = 1'b0;
      run = 1'b1;
      for (int i = 0; i < 40 && !dec_start; i++) cycle();
      setVal = 24'h000005; load = 1'b1; cycle(); load = 1'b0;
      for (int i = 0; i < 20 && dec_start; i++) cycle();
      check_lit("t4_reloaded", 32'(timeAct), 32'h000005);
      check_lit("t4_paused", 32'({dec_start, running, alarm}), 32'h0);
      run = 1'b0;
      cycle();

      // zero time goes straight to alarm; alarm_ack and load exits
      setVal = 24'h000000; load = 1'b1; cycle(); load = 1'b0;
      run = 1'b1; cycle();
      check_lit("t5_alarm", 32'({dec_start, running, alarm}), 32'h1);
      alarm_ack = 1'b1; cycle(); alarm_ack = 1'b0;
      check_lit("t5_acked", 32'({running, alarm}), 32'h0);
      cycle();
      check_lit("t5_idle_ignores_run", 32'(running), 32'h0);
      load = 1'b1; cycle(); load = 1'b0;
      cycle();
      check_lit("t5_alarm_again", 32'(alarm), 32'h1);
      setVal = 24'h000007; load = 1'b1; alarm_ack = 1'b1; cycle(); load = 1'b0; alarm_ack = 1'b0;
      check_lit("t5_load_wins", 32'({running, alarm, timeAct}), 32'h0000007);
      cycle();
      check_lit("t5_paused_then_count", 32'(running), 32'h1);

      // reset during a request, then a stray strobe
      for (int i = 0; i < 40 && !dec_start; i++) cycle();
      check_lit("t6_in_req", 32'(dec_start), 32'h1);
      reset = 1'b1; cycle(); reset = 1'b0;
      check_lit("t6_reset", 32'({dec_start, running, alarm, timeAct}), 32'h0);
      forceComplete = 1; cycle();
      check_lit("t6_stray_strobe", 32'({dec_start, running, alarm, timeAct}), 32'h0);
      cycle();
      check_lit("t6_still_idle", 32'(running), 32'h0);

      // randomized traffic against the model
      chaos = 1;
      for (int i = 0; i < 6000; i++) begin
         reset     = ($urandom_range(0, 599) == 0);
         load      = ($urandom_range(0, 49) == 0);
         alarm_ack = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 24) == 0) run = ~run;
         case ($urandom_range(0, 3))
            0:       setVal = {20'h0, 4'($urandom_range(0, 5))};
            1:       setVal = {16'h0, 4'($urandom_range(0, 2)), 4'($urandom_range(0, 9))};
            2:       setVal = {12'h0, 4'($urandom_range(0, 1)), 8'h00};
            default: setVal = 24'($urandom);
         endcase
         cycle();
      end
      reset = 1'b0; load = 1'b0; alarm_ack = 1'b0; run = 1'b0;
      cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
